csr_file: RTL and testbench

- Control/status register file and exception responder on the receiving end of the writeback stage's exception/CSR interface.
- Consumes committed CSR writes, exception reports (ecode/esubcode/pc) and ertn from writeback.
- Maintains LoongArch-style CRMD/PRMD/ECFG/ESTAT/ERA/EENTRY/SAVE0-3/TID, plus an optional timer.
- Supplies CSR read data to decode and redirect targets/interrupt request to fetch.

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_timer.sv | 38 +++
 rtl/csr_file.sv | 135 +++++++++++++
 tb/tb_csr_file.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR numbers, field positions, writable-bit masks and ecodes for csr_file.
package csr_pkg;
    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    localparam int CRMD_IE   = 2;
    localparam int PRMD_PIE  = 2;
    localparam int ESTAT_TI  = 11;
    localparam int TCFG_EN   = 0;
    localparam int TCFG_PER  = 1;

    localparam logic [31:0] CRMD_WMASK   = 32'h0000_000F;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1FFF;
    localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;

    // Bit-masked CSR write restricted to the register's writable bits.
    function automatic logic [31:0] csr_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [31:0] wmask, input logic [31:0] wr_bits);
        logic [31:0] m;
        m = wmask & wr_bits;
        return (old & ~m) | (wdata & m);
    endfunction
endpackage

// File: rtl/csr_timer.sv
// TCFG/TVAL countdown timer; pulses timer_int_set while armed and TVAL has reached 0.
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tcfg_we,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        timer_int_set
);
    logic        tick_en;
    logic [31:0] tcfg_new;

    assign tcfg_new      = csr_merge(tcfg, wdata, wmask, FULL_WMASK);
    assign timer_int_set = tick_en && (tval == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg    <= 32'h0;
            tval    <= 32'h0;
            tick_en <= 1'b0;
        end else if (tcfg_we) begin
            tcfg    <= tcfg_new;
            tval    <= {tcfg_new[31:2], 2'b00};
            tick_en <= tcfg_new[TCFG_EN];
        end else if (tick_en) begin
            if (tval != 32'h0)
                tval <= tval - 32'h1;
            else if (tcfg[TCFG_PER])
                tval <= {tcfg[31:2], 2'b00};
            else
                tick_en <= 1'b0;
        end
    end
endmodule

// File: rtl/csr_file.sv
// LoongArch-style CSR file and exception responder fed by writeback.
// Optional timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) built when CSR_TIMER_EN is defined.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        wb_ertn,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_csr_wdata,
    input  logic [31:0] wb_csr_wmask,
    input  logic [7:0]  hw_int,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rvalue,
    output logic [31:0] ex_entry,
    output logic [31:0] era_pc,
    output logic        has_int
);
    logic [31:0]      crmd, prmd, ecfg, era, eentry, tid, estat;
    logic [3:0][31:0] save;
    logic [1:0]       estat_sw;
    logic [7:0]       estat_hw;
    logic             estat_ti;
    logic [5:0]       estat_ecode;
    logic [8:0]       estat_esub;
    logic [31:0]      tcfg, tval;

    logic we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_eentry, we_save, we_tid;
    assign we_crmd   = wb_csr_we && (wb_csr_num == CSR_CRMD);
    assign we_prmd   = wb_csr_we && (wb_csr_num == CSR_PRMD);
    assign we_ecfg   = wb_csr_we && (wb_csr_num == CSR_ECFG);
    assign we_estat  = wb_csr_we && (wb_csr_num == CSR_ESTAT);
    assign we_era    = wb_csr_we && (wb_csr_num == CSR_ERA);
    assign we_eentry = wb_csr_we && (wb_csr_num == CSR_EENTRY);
    assign we_save   = wb_csr_we && (wb_csr_num[13:2] == CSR_SAVE0[13:2]);
    assign we_tid    = wb_csr_we && (wb_csr_num == CSR_TID);

    assign estat = {1'b0, estat_esub, estat_ecode, 4'b0, estat_ti, 1'b0, estat_hw, estat_sw};

    // CSR writes first; hardware updates below win on the fields they touch.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd        <= 32'h8;
            prmd        <= 32'h0;
            ecfg        <= 32'h0;
            era         <= 32'h0;
            eentry      <= 32'h0;
            tid         <= TID_INIT;
            save        <= '0;
            estat_sw    <= 2'b0;
            estat_hw    <= 8'b0;
            estat_ecode <= 6'b0;
            estat_esub  <= 9'b0;
        end else begin
            if (we_crmd)   crmd   <= csr_merge(crmd,   wb_csr_wdata, wb_csr_wmask, CRMD_WMASK);
            if (we_prmd)   prmd   <= csr_merge(prmd,   wb_csr_wdata, wb_csr_wmask, PRMD_WMASK);
            if (we_ecfg)   ecfg   <= csr_merge(ecfg,   wb_csr_wdata, wb_csr_wmask, ECFG_WMASK);
            if (we_era)    era    <= csr_merge(era,    wb_csr_wdata, wb_csr_wmask, FULL_WMASK);
            if (we_eentry) eentry <= csr_merge(eentry, wb_csr_wdata, wb_csr_wmask, EENTRY_WMASK);
            if (we_tid)    tid    <= csr_merge(tid,    wb_csr_wdata, wb_csr_wmask, FULL_WMASK);
            if (we_save)
                save[wb_csr_num[1:0]] <= csr_merge(save[wb_csr_num[1:0]], wb_csr_wdata,
                                                   wb_csr_wmask, FULL_WMASK);
            if (we_estat)
                estat_sw <= (estat_sw & ~wb_csr_wmask[1:0]) | (wb_csr_wdata[1:0] & wb_csr_wmask[1:0]);
            estat_hw <= hw_int;
            if (wb_ex) begin
                prmd[2:0]   <= crmd[2:0];
                crmd[2:0]   <= 3'b0;
                estat_ecode <= wb_ecode;
                estat_esub  <= wb_esubcode;
                era         <= wb_pc;
            end else if (wb_ertn) begin
                crmd[2:0]   <= prmd[2:0];
            end
        end
    end

`ifdef CSR_TIMER_EN
    logic timer_int_set;

    csr_timer u_timer (
        .clk           (clk),
        .reset         (reset),
        .tcfg_we       (wb_csr_we && (wb_csr_num == CSR_TCFG)),
        .wdata         (wb_csr_wdata),
        .wmask         (wb_csr_wmask),
        .tcfg          (tcfg),
        .tval          (tval),
        .timer_int_set (timer_int_set)
    );

    // A timer set beats a same-cycle TICLR clear.
    always_ff @(posedge clk) begin
        if (reset)
            estat_ti <= 1'b0;
        else if (timer_int_set)
            estat_ti <= 1'b1;
        else if (wb_csr_we && (wb_csr_num == CSR_TICLR) && wb_csr_wdata[0] && wb_csr_wmask[0])
            estat_ti <= 1'b0;
    end
`else
    assign tcfg     = 32'h0;
    assign tval     = 32'h0;
    assign estat_ti = 1'b0;
`endif

    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_rnum)
            CSR_CRMD:   csr_rvalue = crmd;
            CSR_PRMD:   csr_rvalue = prmd;
            CSR_ECFG:   csr_rvalue = ecfg;
            CSR_ESTAT:  csr_rvalue = estat;
            CSR_ERA:    csr_rvalue = era;
            CSR_EENTRY: csr_rvalue = eentry;
            14'h30, 14'h31, 14'h32, 14'h33: csr_rvalue = save[csr_rnum[1:0]];
            CSR_TID:    csr_rvalue = tid;
            CSR_TCFG:   csr_rvalue = tcfg;
            CSR_TVAL:   csr_rvalue = tval;
            default:    csr_rvalue = 32'h0;
        endcase
    end

    assign ex_entry = eentry;
    assign era_pc   = era;
    assign has_int  = crmd[CRMD_IE] && |(estat[12:0] & ecfg[12:0]);
endmodule

// File: tb/tb_csr_file.sv
// Randomized and directed bench for csr_file against a register-level reference model.
module tb_csr_file;
    localparam logic [31:0] TID_V = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex, wb_ertn, wb_csr_we;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_csr_wdata, wb_csr_wmask;
    logic [13:0] wb_csr_num, csr_rnum;
    logic [7:0]  hw_int;
    logic [31:0] csr_rvalue, ex_entry, era_pc;
    logic        has_int;

    int n_chk = 0;
    int n_pass = 0;

    csr_file #(.TID_INIT(TID_V)) dut (
        .clk(clk), .reset(reset), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_ertn(wb_ertn), .wb_csr_we(wb_csr_we), .wb_csr_num(wb_csr_num),
        .wb_csr_wdata(wb_csr_wdata), .wb_csr_wmask(wb_csr_wmask), .hw_int(hw_int),
        .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue), .ex_entry(ex_entry), .era_pc(era_pc),
        .has_int(has_int)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register values.
    logic [31:0] m_crmd, m_prmd, m_ecfg, m_estat, m_era, m_eentry, m_tid, m_tcfg, m_tval;
    logic [31:0] m_save [4];
    bit          m_ten;

    function automatic logic [31:0] wr(input logic [31:0] old, input logic [13:0] num,
                                       input logic [31:0] writable);
        if (wb_csr_we && wb_csr_num == num)
            return (old & ~(wb_csr_wmask & writable)) | (wb_csr_wdata & wb_csr_wmask & writable);
        return old;
    endfunction

    function automatic logic [31:0] mread(input logic [13:0] num);
        case (num)
            14'h00: return m_crmd;
            14'h01: return m_prmd;
            14'h04: return m_ecfg;
            14'h05: return m_estat;
            14'h06: return m_era;
            14'h0C: return m_eentry;
            14'h30: return m_save[0];
            14'h31: return m_save[1];
            14'h32: return m_save[2];
            14'h33: return m_save[3];
            14'h40: return m_tid;
`ifdef CSR_TIMER_EN
            14'h41: return m_tcfg;
            14'h42: return m_tval;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_has_int();
        return m_crmd[2] && (|(m_estat[12:0] & m_ecfg[12:0]));
    endfunction

    task automatic model_reset();
        m_crmd = 32'h8; m_prmd = 0; m_ecfg = 0; m_estat = 0; m_era = 0; m_eentry = 0;
        m_tid = TID_V; m_tcfg = 0; m_tval = 0; m_ten = 0;
        for (int i = 0; i < 4; i++) m_save[i] = 0;
    endtask

    task automatic model_update();
        logic [31:0] n_crmd, n_prmd, n_estat, n_era, n_tcfg, n_tval;
        bit          n_ten, tset;
        n_crmd  = wr(m_crmd, 14'h00, 32'hF);
        n_prmd  = wr(m_prmd, 14'h01, 32'h7);
        n_estat = wr(m_estat, 14'h05, 32'h3);
        n_era   = wr(m_era, 14'h06, 32'hFFFF_FFFF);
        n_estat[9:2] = hw_int;
        n_tcfg = m_tcfg; n_tval = m_tval; n_ten = m_ten;
`ifdef CSR_TIMER_EN
        tset = m_ten && (m_tval == 0);
        if (wb_csr_we && wb_csr_num == 14'h41) begin
            n_tcfg = wr(m_tcfg, 14'h41, 32'hFFFF_FFFF);
            n_tval = {n_tcfg[31:2], 2'b00};
            n_ten  = n_tcfg[0];
        end else if (m_ten) begin
            if (m_tval != 0) n_tval = m_tval - 1;
            else if (m_tcfg[1]) n_tval = {m_tcfg[31:2], 2'b00};
            else n_ten = 0;
        end
        if (wb_csr_we && wb_csr_num == 14'h44 && wb_csr_wdata[0] && wb_csr_wmask[0]) n_estat[11] = 0;
        if (tset) n_estat[11] = 1;
`else
        tset = 0;
`endif
        if (wb_ex) begin
            n_prmd[1:0] = m_crmd[1:0];
            n_prmd[2]   = m_crmd[2];
            n_crmd[2:0] = 3'b0;
            n_estat[21:16] = wb_ecode;
            n_estat[30:22] = wb_esubcode;
            n_era = wb_pc;
        end else if (wb_ertn) begin
            n_crmd[1:0] = m_prmd[1:0];
            n_crmd[2]   = m_prmd[2];
        end
        m_ecfg   = wr(m_ecfg, 14'h04, 32'h1FFF);
        m_eentry = wr(m_eentry, 14'h0C, 32'hFFFF_FFC0);
        m_tid    = wr(m_tid, 14'h40, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) m_save[i] = wr(m_save[i], 14'h30 + 14'(i), 32'hFFFF_FFFF);
        m_crmd = n_crmd; m_prmd = n_prmd; m_estat = n_estat; m_era = n_era;
        m_tcfg = n_tcfg; m_tval = n_tval; m_ten = n_ten;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_update();
        #1;
    endtask

    task automatic idle();
        wb_ex = 0; wb_ertn = 0; wb_csr_we = 0; wb_ecode = 0; wb_esubcode = 0; wb_pc = 0;
        wb_csr_num = 0; wb_csr_wdata = 0; wb_csr_wmask = 0;
    endtask

    task automatic csr_write(input logic [13:0] num, input logic [31:0] data);
        wb_csr_we = 1; wb_csr_num = num; wb_csr_wdata = data; wb_csr_wmask = 32'hFFFF_FFFF;
        step();
        idle();
    endtask

    task automatic test_reset();
        reset = 1; idle(); hw_int = 0; csr_rnum = 14'h0;
        step(); step();
        reset = 0; #1;
        n_chk++; if (csr_rvalue !== 32'h8) $display("FAIL reset_crmd: got %h want %h", csr_rvalue, 32'h8); else n_pass++;
        csr_rnum = 14'h06; #1;
        n_chk++; if (csr_rvalue !== 32'h0) $display("FAIL reset_era: got %h want 0", csr_rvalue); else n_pass++;
        csr_rnum = 14'h40; #1;
        n_chk++; if (csr_rvalue !== TID_V) $display("FAIL reset_tid: got %h want %h", csr_rvalue, TID_V); else n_pass++;
        n_chk++; if (has_int !== 1'b0) $display("FAIL reset_has_int: got %b want 0", has_int); else n_pass++;
    endtask

    task automatic test_eentry();
        csr_write(14'h0C, 32'h1C00_8FFF);
        csr_rnum = 14'h0C; #1;
        n_chk++; if (csr_rvalue !== 32'h1C00_8FC0) $display("FAIL eentry_read: got %h want %h", csr_rvalue, 32'h1C00_8FC0); else n_pass++;
        n_chk++; if (ex_entry !== 32'h1C00_8FC0) $display("FAIL ex_entry: got %h want %h", ex_entry, 32'h1C00_8FC0); else n_pass++;
    endtask

    task automatic test_exception();
        csr_write(14'h00, 32'h7);
        wb_ex = 1; wb_ecode = 6'hB; wb_esubcode = 0; wb_pc = 32'h1C00_0100;
        step(); idle();
        csr_rnum = 14'h00; #1;
        n_chk++; if (csr_rvalue !== 32'h0) $display("FAIL ex_crmd: got %h want 0", csr_rvalue); else n_pass++;
        csr_rnum = 14'h01; #1;
        n_chk++; if (csr_rvalue !== 32'h7) $display("FAIL ex_prmd: got %h want 7", csr_rvalue); else n_pass++;
        csr_rnum = 14'h05; #1;
        n_chk++; if (csr_rvalue[21:16] !== 6'hB) $display("FAIL ex_ecode: got %h want b", csr_rvalue[21:16]); else n_pass++;
        n_chk++; if (era_pc !== 32'h1C00_0100) $display("FAIL ex_era_pc: got %h want %h", era_pc, 32'h1C00_0100); else n_pass++;
        wb_ertn = 1; step(); idle();
        csr_rnum = 14'h00; #1;
        n_chk++; if (csr_rvalue[2:0] !== 3'h7) $display("FAIL ertn_crmd: got %h want 7", csr_rvalue[2:0]); else n_pass++;
    endtask

    task automatic test_ex_vs_write();
        wb_ex = 1; wb_ecode = 6'h9; wb_pc = 32'h1C00_0200;
        wb_csr_we = 1; wb_csr_num = 14'h00; wb_csr_wdata = 32'h4; wb_csr_wmask = 32'hFFFF_FFFF;
        step(); idle();
        csr_rnum = 14'h00; #1;
        n_chk++; if (csr_rvalue[2] !== 1'b0) $display("FAIL ex_wins_ie: got %b want 0", csr_rvalue[2]); else n_pass++;
        n_chk++; if (csr_rvalue !== 32'h0) $display("FAIL ex_wins_crmd: got %h want 0", csr_rvalue); else n_pass++;
    endtask

    task automatic test_interrupt();
        csr_write(14'h04, 32'h4);
        csr_write(14'h00, 32'h4);
        hw_int = 8'h01; #1;
        n_chk++; if (has_int !== 1'b0) $display("FAIL int_latency: got %b want 0", has_int); else n_pass++;
        step();
        n_chk++; if (has_int !== 1'b1) $display("FAIL int_raise: got %b want 1", has_int); else n_pass++;
        hw_int = 8'h00; step();
        n_chk++; if (has_int !== 1'b0) $display("FAIL int_drop: got %b want 0", has_int); else n_pass++;
    endtask

`ifdef CSR_TIMER_EN
    task automatic test_timer();
        csr_write(14'h04, 32'h800);
        csr_write(14'h00, 32'h4);
        csr_write(14'h41, 32'h0000_0011);
        csr_rnum = 14'h42;
        for (int i = 16; i >= 0; i--) begin
            #1;
            n_chk++; if (csr_rvalue !== 32'(i)) $display("FAIL timer_tval: got %0d want %0d", csr_rvalue, i); else n_pass++;
            if (i > 0) step();
        end
        step();
        n_chk++; if (csr_rvalue !== 32'h0) $display("FAIL timer_hold: got %0d want 0", csr_rvalue); else n_pass++;
        csr_rnum = 14'h05; #1;
        n_chk++; if (csr_rvalue[11] !== 1'b1) $display("FAIL timer_is11: got %b want 1", csr_rvalue[11]); else n_pass++;
        n_chk++; if (has_int !== 1'b1) $display("FAIL timer_has_int: got %b want 1", has_int); else n_pass++;
        csr_write(14'h44, 32'h1);
        #1;
        n_chk++; if (csr_rvalue[11] !== 1'b0) $display("FAIL ticlr: got %b want 0", csr_rvalue[11]); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [13:0] nums [16];
        nums = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h0C, 14'h30, 14'h31,
                 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h07, 14'h1FF};
        for (int c = 0; c < 400; c++) begin
            wb_csr_we    = ($urandom_range(1, 0) == 1);
            wb_csr_num   = nums[$urandom_range(15, 0)];
            wb_csr_wdata = $urandom;
            wb_csr_wmask = ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFF : $urandom;
            if (wb_csr_num == 14'h41) wb_csr_wdata[31:8] = 0;
            wb_ex        = ($urandom_range(9, 0) == 0);
            wb_ertn      = ($urandom_range(9, 0) == 0);
            wb_ecode     = 6'($urandom);
            wb_esubcode  = 9'($urandom);
            wb_pc        = $urandom;
            if ($urandom_range(3, 0) == 0) hw_int = 8'($urandom);
            csr_rnum     = nums[$urandom_range(15, 0)];
            step();
            n_chk++; if (csr_rvalue !== mread(csr_rnum)) $display("FAIL rand_read[%0d] num %h: got %h want %h", c, csr_rnum, csr_rvalue, mread(csr_rnum)); else n_pass++;
            n_chk++; if (has_int !== m_has_int()) $display("FAIL rand_has_int[%0d]: got %b want %b", c, has_int, m_has_int()); else n_pass++;
            n_chk++; if (ex_entry !== m_eentry || era_pc !== m_era) $display("FAIL rand_targets[%0d]: got %h/%h want %h/%h", c, ex_entry, era_pc, m_eentry, m_era); else n_pass++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_eentry();
        test_exception();
        test_ex_vs_write();
        test_interrupt();
`ifdef CSR_TIMER_EN
        test_timer();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
